// File: rtl/dat_mem_dma_if.sv
// dat_mem_dma_if: bundles the copy-engine control, CPU port and memory port
//   slave  : seen by dat_mem_dma (takes copy requests and CPU traffic, drives the memory)
//   master : seen by whoever drives copy requests and CPU traffic and holds the memory
//   start/src/dst/len   copy request; busy/done/remaining copy status
//   cpu_req/cpu_wr_en/cpu_addr/cpu_din/cpu_dout   processor load/store path
//   mem_addr/mem_din/mem_wr_en/mem_dout            single memory port
interface dat_mem_dma_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          start;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic [AW-1:0] remaining;
    logic          cpu_req;
    logic          cpu_wr_en;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_wr_en;
    logic [DW-1:0] mem_dout;
    modport slave (
        input  start, src, dst, len, cpu_req, cpu_wr_en, cpu_addr, cpu_din, mem_dout,
        output busy, done, remaining, cpu_dout, mem_addr, mem_din, mem_wr_en
    );
    modport master (
        output start, src, dst, len, cpu_req, cpu_wr_en, cpu_addr, cpu_din, mem_dout,
        input  busy, done, remaining, cpu_dout, mem_addr, mem_din, mem_wr_en
    );
endinterface

// File: rtl/dat_mem_dma.sv
// dat_mem_dma: arbiter and byte-copy engine sharing one memory port with the CPU
//   clk    clock, all state updates on posedge
//   reset  asynchronous active-high, aborts any copy and returns to IDLE
//   bus    dat_mem_dma_if.slave: copy request/status, CPU path, memory port
module dat_mem_dma #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input logic         clk,
    input logic         reset,
    dat_mem_dma_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t        state, state_nx;
    logic [AW-1:0] src_ptr, dst_ptr, rem;
    logic [DW-1:0] data_buf;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;
    // The CPU always owns the port when it asks; the engine only advances in cycles it is idle.
    always_comb begin
        state_nx      = state;
        bus.mem_addr  = '0;
        bus.mem_din   = '0;
        bus.mem_wr_en = 1'b0;
        case (state)
            IDLE:    if (bus.start) state_nx = (bus.len == '0) ? DONE : RD;
            RD:      if (!bus.cpu_req) state_nx = WR;
            WR:      if (!bus.cpu_req) state_nx = (rem == AW'(1)) ? DONE : RD;
            default: state_nx = IDLE;
        endcase
        if (bus.cpu_req) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_din   = bus.cpu_din;
            bus.mem_wr_en = bus.cpu_wr_en;
        end else if (state == RD) begin
            bus.mem_addr  = src_ptr;
        end else if (state == WR) begin
            bus.mem_addr  = dst_ptr;
            bus.mem_din   = data_buf;
            bus.mem_wr_en = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            rem      <= '0;
            data_buf <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start && bus.len != '0) begin
                    src_ptr <= bus.src;
                    dst_ptr <= bus.dst;
                    rem     <= bus.len;
                end
                RD: if (!bus.cpu_req) data_buf <= bus.mem_dout;
                WR: if (!bus.cpu_req) begin
                    src_ptr <= src_ptr + AW'(1);
                    dst_ptr <= dst_ptr + AW'(1);
                    rem     <= rem - AW'(1);
                end
                default: ;
            endcase
        end
    assign bus.busy      = (state == RD) || (state == WR);
    assign bus.done      = (state == DONE);
    assign bus.remaining = rem;
    assign bus.cpu_dout  = bus.mem_dout;
endmodule

// File: tb/tb_dat_mem_dma.sv
// tb_dat_mem_dma: directed checks of dat_mem_dma against a 256x8 memory model
module tb_dat_mem_dma;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done;
    logic [7:0] mem [256];
    int   t1_rem [7] = '{3, 3, 2, 2, 1, 1, 0};
    int   t4_addr [4] = '{254, 255, 0, 1};

    dat_mem_dma_if bus ();
    dat_mem_dma dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_din;
    assign bus.mem_dout = mem[bus.mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        bus.cpu_req = 1'b1;
        bus.cpu_wr_en = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_din = d;
        step();
        bus.cpu_req = 1'b0;
        bus.cpu_wr_en = 1'b0;
    endtask

    task automatic mem_check(input string tag, input logic [7:0] a, input logic [7:0] e);
        bus.cpu_req = 1'b1;
        bus.cpu_wr_en = 1'b0;
        bus.cpu_addr = a;
        #1;
        check(tag, 32'(bus.cpu_dout), 32'(e));
        bus.cpu_req = 1'b0;
        #1;
    endtask

    task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        bus.src = s;
        bus.dst = d;
        bus.len = l;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.src = '0;
        bus.dst = '0;
        bus.len = '0;
        bus.cpu_req = 1'b0;
        bus.cpu_wr_en = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_din = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_rem", 32'(bus.remaining), 0);
        check("rst_wr_en", 32'(bus.mem_wr_en), 0);
        step();
        step();
        reset = 1'b0;
        step();

        // 1: uncontended 3-byte copy
        cpu_write(60, 8'h10);
        cpu_write(61, 8'hE0);
        cpu_write(62, 8'hF0);
        start_copy(60, 100, 3);
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("t1_rem_c%0d", c), 32'(bus.remaining), 32'(t1_rem[c-1]));
            check($sformatf("t1_busy_c%0d", c), 32'(bus.busy), 32'(c <= 6));
            check($sformatf("t1_done_c%0d", c), 32'(bus.done), 32'(c == 7));
            step();
        end
        check("t1_idle_done", 32'(bus.done), 0);
        mem_check("t1_m100", 100, 8'h10);
        mem_check("t1_m101", 101, 8'hE0);
        mem_check("t1_m102", 102, 8'hF0);

        // 2: CPU write to the source mid-stall is seen by the copy
        start_copy(60, 100, 3);
        for (int c = 1; c <= 11; c++) begin
            bus.cpu_req = (c <= 4);
            bus.cpu_wr_en = (c <= 4);
            bus.cpu_addr = 61;
            bus.cpu_din = 8'hAA;
            #1;
            if (c <= 4) check($sformatf("t2_cpu_addr_c%0d", c), 32'(bus.mem_addr), 61);
            check($sformatf("t2_done_c%0d", c), 32'(bus.done), 32'(c == 11));
            step();
        end
        bus.cpu_req = 1'b0;
        bus.cpu_wr_en = 1'b0;
        mem_check("t2_m61", 61, 8'hAA);
        mem_check("t2_m100", 100, 8'h10);
        mem_check("t2_m101", 101, 8'hAA);
        mem_check("t2_m102", 102, 8'hF0);

        // 3: zero-length request
        start_copy(60, 100, 0);
        check("t3_done_c1", 32'(bus.done), 1);
        check("t3_busy_c1", 32'(bus.busy), 0);
        check("t3_wr_en_c1", 32'(bus.mem_wr_en), 0);
        step();
        check("t3_done_c2", 32'(bus.done), 0);
        check("t3_busy_c2", 32'(bus.busy), 0);
        mem_check("t3_m100", 100, 8'h10);

        // 4: source wraps 255 -> 0
        cpu_write(254, 8'h01);
        cpu_write(255, 8'h02);
        cpu_write(0, 8'h03);
        cpu_write(1, 8'h04);
        start_copy(254, 10, 4);
        for (int c = 1; c <= 9; c++) begin
            if (c % 2 == 1 && c < 9) begin
                check($sformatf("t4_rd_addr_c%0d", c), 32'(bus.mem_addr), 32'(t4_addr[(c-1)/2]));
                check($sformatf("t4_rd_wr_en_c%0d", c), 32'(bus.mem_wr_en), 0);
            end
            if (c % 2 == 0) check($sformatf("t4_wr_en_c%0d", c), 32'(bus.mem_wr_en), 1);
            check($sformatf("t4_done_c%0d", c), 32'(bus.done), 32'(c == 9));
            step();
        end
        mem_check("t4_m10", 10, 8'h01);
        mem_check("t4_m11", 11, 8'h02);
        mem_check("t4_m12", 12, 8'h03);
        mem_check("t4_m13", 13, 8'h04);

        // 5: reset after the first write aborts the copy
        cpu_write(201, 8'h55);
        cpu_write(202, 8'h66);
        start_copy(60, 200, 3);
        step();
        step();
        reset = 1'b1;
        #1;
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_rem", 32'(bus.remaining), 0);
        check("t5_done", 32'(bus.done), 0);
        check("t5_wr_en", 32'(bus.mem_wr_en), 0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t5_no_done_%0d", c), 32'(bus.done), 0);
            step();
        end
        mem_check("t5_m200", 200, 8'h10);
        mem_check("t5_m201", 201, 8'h55);
        mem_check("t5_m202", 202, 8'h66);
        start_copy(60, 150, 1);
        check("t5_restart_busy", 32'(bus.busy), 1);
        step();
        step();
        check("t5_restart_done", 32'(bus.done), 1);
        step();
        mem_check("t5_m150", 150, 8'h10);

        // 6: forward overlap plus a start that must be ignored
        cpu_write(20, 8'h07);
        cpu_write(21, 8'h09);
        start_copy(20, 21, 2);
        n_done = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin
                bus.start = 1'b1;
                bus.len = 5;
                bus.src = 0;
                bus.dst = 0;
            end
            if (c == 3) bus.start = 1'b0;
            #1;
            n_done += int'(bus.done);
            check($sformatf("t6_done_c%0d", c), 32'(bus.done), 32'(c == 5));
            step();
        end
        check("t6_done_count", 32'(n_done), 1);
        mem_check("t6_m21", 21, 8'h07);
        mem_check("t6_m22", 22, 8'h07);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
